// File: rtl/dmem_port_arbiter_if.sv
// Bundle of signals between the two requesters, the data memory and the arbiter.
// The arbiter uses the slave view; requesters and memory use the master view.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic [DATA_W-1:0] core_rdata;
  logic              core_ack;
  logic              core_stall;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_ack;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_rdata, core_ack, core_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_rdata, core_ack, core_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the core
// load/store path and the debug/loader port, with a fixed-latency access sequence.
module dmem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input logic                clk,
  input logic                reset,
  dmem_port_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t            state;
  logic              ptr_dbg;   // 1: debug port wins the next tie
  logic              sel_dbg;   // latched winner of the current access
  logic              lat_we;
  logic [CNT_W-1:0]  cnt;

  logic              grant_dbg;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  // A lone requester always wins; on a tie the pointer decides.
  assign grant_dbg = bus.dbg_req & (~bus.core_req | ptr_dbg);
  assign win_we    = grant_dbg ? bus.dbg_we    : bus.core_we;
  assign win_addr  = grant_dbg ? bus.dbg_addr  : bus.core_addr;
  assign win_wdata = grant_dbg ? bus.dbg_wdata : bus.core_wdata;

  assign bus.core_stall = bus.core_req & ~bus.core_ack;

  // NOTE: every register here uses <= so all of them see pre-edge values,
  // independent of statement order inside the block.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      ptr_dbg        <= 1'b0;
      sel_dbg        <= 1'b0;
      lat_we         <= 1'b0;
      cnt            <= '0;
      bus.core_rdata <= '0;
      bus.core_ack   <= 1'b0;
      bus.dbg_rdata  <= '0;
      bus.dbg_ack    <= 1'b0;
      bus.mem_en     <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.busy       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.core_req || bus.dbg_req) begin
            sel_dbg       <= grant_dbg;
            lat_we        <= win_we;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= win_we;
            bus.mem_addr  <= win_addr;   // mem_addr/mem_wdata double as the request latch
            bus.mem_wdata <= win_wdata;
            bus.busy      <= 1'b1;
            if (bus.core_req && bus.dbg_req) ptr_dbg <= ~grant_dbg;
            state         <= ACCESS;
          end
        end
        ACCESS: begin
          bus.mem_en <= 1'b0;
          bus.mem_we <= 1'b0;
          cnt        <= CNT_W'(MEM_LAT);
          state      <= WAIT;
        end
        WAIT: begin
          if (cnt == CNT_W'(1)) begin
            // mem_rdata is valid in this final wait cycle; writes keep old rdata.
            if (!lat_we) begin
              if (sel_dbg) bus.dbg_rdata  <= bus.mem_rdata;
              else         bus.core_rdata <= bus.mem_rdata;
            end
            if (sel_dbg) bus.dbg_ack  <= 1'b1;
            else         bus.core_ack <= 1'b1;
            state <= RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          bus.core_ack <= 1'b0;
          bus.dbg_ack  <= 1'b0;
          bus.busy     <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scenario bench for dmem_port_arbiter: a MEM_LAT=2 instance and a MEM_LAT=1
// instance, each backed by a small pipelined memory model.
module tb_dmem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

  dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut1 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus1)
  );

  // Memory model, latency 2: data appears two cycles after the mem_en cycle.
  logic [DW-1:0] mem0 [256];
  logic [DW-1:0] p1 = '0, p2 = '0;
  logic          v1 = 1'b0, v2 = 1'b0;
  always @(posedge clk) begin
    v1 <= bus.mem_en & ~bus.mem_we;
    p1 <= mem0[bus.mem_addr[7:0]];
    v2 <= v1;
    p2 <= p1;
    if (bus.mem_en && bus.mem_we) mem0[bus.mem_addr[7:0]] = bus.mem_wdata;
  end
  assign bus.mem_rdata = v2 ? p2 : 32'hDEAD_BEEF;

  // Memory model, latency 1.
  logic [DW-1:0] mem1 [256];
  logic [DW-1:0] q1 = '0;
  logic          w1 = 1'b0;
  always @(posedge clk) begin
    w1 <= bus1.mem_en & ~bus1.mem_we;
    q1 <= mem1[bus1.mem_addr[7:0]];
    if (bus1.mem_en && bus1.mem_we) mem1[bus1.mem_addr[7:0]] = bus1.mem_wdata;
  end
  assign bus1.mem_rdata = w1 ? q1 : 32'hDEAD_BEEF;

  typedef struct packed {
    logic          dbg;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    step();
    @(negedge clk);
    n_checks++;
    if ({bus.core_ack, bus.dbg_ack, bus.mem_en, bus.mem_we, bus.busy, bus.core_stall} !== 6'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {bus.core_ack, bus.dbg_ack, bus.mem_en, bus.mem_we, bus.busy, bus.core_stall});
    end
    n_checks++;
    if ({bus.core_rdata, bus.dbg_rdata, bus.mem_addr, bus.mem_wdata} !== 128'b0) begin
      n_errors++;
      $display("FAIL reset_data: core_rdata=%h dbg_rdata=%h mem_addr=%h mem_wdata=%h expected all 0",
               bus.core_rdata, bus.dbg_rdata, bus.mem_addr, bus.mem_wdata);
    end
    n_checks++;
    if ({bus1.core_ack, bus1.mem_en, bus1.busy} !== 3'b0) begin
      n_errors++;
      $display("FAIL reset_lat1: got %b expected 000", {bus1.core_ack, bus1.mem_en, bus1.busy});
    end
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_core_load();
    exp_t e;
    mem0[8'h10] = 32'd30;
    bus.core_req  = 1'b1;
    bus.core_we   = 1'b0;
    bus.core_addr = 32'h10;
    sb.push_back('{1'b0, 32'd30});
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.core_stall !== (c < 4)) begin
        n_errors++;
        $display("FAIL core_load_stall c=%0d: got %b expected %b", c, bus.core_stall, (c < 4));
      end
      n_checks++;
      if (bus.mem_en !== (c == 1)) begin
        n_errors++;
        $display("FAIL core_load_mem_en c=%0d: got %b expected %b", c, bus.mem_en, (c == 1));
      end
      if (c == 1) begin
        n_checks++;
        if ({bus.mem_we, bus.mem_addr} !== {1'b0, 32'h10}) begin
          n_errors++;
          $display("FAIL core_load_mem_addr: got we=%b addr=%h expected we=0 addr=10",
                   bus.mem_we, bus.mem_addr);
        end
      end
      n_checks++;
      if (bus.core_ack !== (c == 4)) begin
        n_errors++;
        $display("FAIL core_load_ack c=%0d: got %b expected %b", c, bus.core_ack, (c == 4));
      end
      if (bus.core_ack || bus.dbg_ack) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_errors++;
          $display("FAIL core_load_sb: unexpected ack at c=%0d, expected none", c);
        end else begin
          e = sb.pop_front();
          if ({bus.dbg_ack, bus.dbg_ack ? bus.dbg_rdata : bus.core_rdata} !== e) begin
            n_errors++;
            $display("FAIL core_load_data: got port=%b data=%0d expected port=%b data=%0d",
                     bus.dbg_ack, bus.dbg_ack ? bus.dbg_rdata : bus.core_rdata, e.dbg, e.data);
          end
        end
      end
      step();
      if (c == 4) bus.core_req = 1'b0;
    end
  endtask

  task automatic test_dbg_write_core_read();
    exp_t e;
    mem0[8'h04] = 32'd0;
    bus.dbg_req   = 1'b1;
    bus.dbg_we    = 1'b1;
    bus.dbg_addr  = 32'h4;
    bus.dbg_wdata = 32'd200;
    sb.push_back('{1'b1, 32'd0});   // a write leaves dbg_rdata at its reset value
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.mem_en !== (c == 1 || c == 6)) begin
        n_errors++;
        $display("FAIL wr_rd_mem_en c=%0d: got %b expected %b", c, bus.mem_en, (c == 1 || c == 6));
      end
      if (c == 1) begin
        n_checks++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 32'h4, 32'd200}) begin
          n_errors++;
          $display("FAIL wr_rd_write: got we=%b addr=%h wdata=%0d expected we=1 addr=4 wdata=200",
                   bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
      end
      if (c == 6) begin
        n_checks++;
        if ({bus.mem_we, bus.mem_addr} !== {1'b0, 32'h4}) begin
          n_errors++;
          $display("FAIL wr_rd_read: got we=%b addr=%h expected we=0 addr=4", bus.mem_we, bus.mem_addr);
        end
      end
      n_checks++;
      if ({bus.dbg_ack, bus.core_ack} !== {1'(c == 4), 1'(c == 9)}) begin
        n_errors++;
        $display("FAIL wr_rd_acks c=%0d: got dbg=%b core=%b expected dbg=%b core=%b",
                 c, bus.dbg_ack, bus.core_ack, (c == 4), (c == 9));
      end
      if (bus.core_ack || bus.dbg_ack) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_errors++;
          $display("FAIL wr_rd_sb: unexpected ack at c=%0d, expected none", c);
        end else begin
          e = sb.pop_front();
          if ({bus.dbg_ack, bus.dbg_ack ? bus.dbg_rdata : bus.core_rdata} !== e) begin
            n_errors++;
            $display("FAIL wr_rd_data: got port=%b data=%0d expected port=%b data=%0d",
                     bus.dbg_ack, bus.dbg_ack ? bus.dbg_rdata : bus.core_rdata, e.dbg, e.data);
          end
        end
      end
      step();
      if (c == 4) begin
        bus.dbg_req   = 1'b0;
        bus.core_req  = 1'b1;
        bus.core_we   = 1'b0;
        bus.core_addr = 32'h4;
        sb.push_back('{1'b0, 32'd200});
      end
      if (c == 9) bus.core_req = 1'b0;
    end
    n_checks++;
    if (bus.dbg_rdata !== 32'd0) begin
      n_errors++;
      $display("FAIL wr_rd_dbg_rdata_hold: got %0d expected 0", bus.dbg_rdata);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.core_req  = 1'b1;
    bus.core_we   = 1'b0;
    bus.core_addr = 32'h10;
    bus.dbg_req   = 1'b1;
    bus.dbg_we    = 1'b0;
    bus.dbg_addr  = 32'h4;
    sb.push_back('{1'b0, 32'd30});
    sb.push_back('{1'b1, 32'd200});
    sb.push_back('{1'b0, 32'd30});
    sb.push_back('{1'b1, 32'd200});
    for (int c = 0; c <= 21; c++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.core_ack, bus.dbg_ack} !== {1'(c == 4 || c == 14), 1'(c == 9 || c == 19)}) begin
        n_errors++;
        $display("FAIL b2b_acks c=%0d: got core=%b dbg=%b expected core=%b dbg=%b",
                 c, bus.core_ack, bus.dbg_ack, (c == 4 || c == 14), (c == 9 || c == 19));
      end
      n_checks++;
      if (bus.busy !== (c % 5 != 0 && c < 20)) begin
        n_errors++;
        $display("FAIL b2b_busy c=%0d: got %b expected %b", c, bus.busy, (c % 5 != 0 && c < 20));
      end
      if (bus.core_ack || bus.dbg_ack) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_errors++;
          $display("FAIL b2b_sb: unexpected ack at c=%0d, expected none", c);
        end else begin
          e = sb.pop_front();
          if ({bus.dbg_ack, bus.dbg_ack ? bus.dbg_rdata : bus.core_rdata} !== e) begin
            n_errors++;
            $display("FAIL b2b_order c=%0d: got port=%b data=%0d expected port=%b data=%0d",
                     c, bus.dbg_ack, bus.dbg_ack ? bus.dbg_rdata : bus.core_rdata, e.dbg, e.data);
          end
        end
      end
      step();
      if (c == 19) begin
        bus.core_req = 1'b0;
        bus.dbg_req  = 1'b0;
      end
    end
  endtask

  task automatic test_addr_change();
    exp_t e;
    mem0[8'h20] = 32'd99;
    bus.core_req  = 1'b1;
    bus.core_we   = 1'b0;
    bus.core_addr = 32'h10;
    sb.push_back('{1'b0, 32'd30});
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.mem_en, bus.mem_en ? bus.mem_addr : 32'h10} !== {1'(c == 1), 32'h10}) begin
        n_errors++;
        $display("FAIL addr_chg_mem c=%0d: got en=%b addr=%h expected en=%b addr=10",
                 c, bus.mem_en, bus.mem_addr, (c == 1));
      end
      if (bus.core_ack || bus.dbg_ack) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_errors++;
          $display("FAIL addr_chg_sb: unexpected ack at c=%0d, expected none", c);
        end else begin
          e = sb.pop_front();
          if ({bus.dbg_ack, bus.dbg_ack ? bus.dbg_rdata : bus.core_rdata} !== e || c != 4) begin
            n_errors++;
            $display("FAIL addr_chg_data c=%0d: got port=%b data=%0d expected port=%b data=%0d at c=4",
                     c, bus.dbg_ack, bus.dbg_ack ? bus.dbg_rdata : bus.core_rdata, e.dbg, e.data);
          end
        end
      end
      step();
      if (c == 1) begin
        bus.core_addr = 32'h20;
        bus.core_we   = 1'b1;
      end
      if (c == 4) bus.core_req = 1'b0;
    end
  endtask

  task automatic test_reset_abort();
    exp_t e;
    bus.dbg_req  = 1'b1;
    bus.dbg_we   = 1'b0;
    bus.dbg_addr = 32'h10;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      if (c == 3) begin
        n_checks++;
        if ({bus.busy, bus.mem_en, bus.dbg_ack} !== 3'b0) begin
          n_errors++;
          $display("FAIL abort_idle: got busy=%b mem_en=%b dbg_ack=%b expected 0 0 0",
                   bus.busy, bus.mem_en, bus.dbg_ack);
        end
      end
      n_checks++;
      if ({bus.dbg_ack, bus.core_ack} !== {1'b0, 1'(c == 9)}) begin
        n_errors++;
        $display("FAIL abort_acks c=%0d: got dbg=%b core=%b expected dbg=0 core=%b",
                 c, bus.dbg_ack, bus.core_ack, (c == 9));
      end
      if (c == 6) begin
        n_checks++;
        if ({bus.mem_en, bus.mem_addr} !== {1'b1, 32'h10}) begin
          n_errors++;
          $display("FAIL abort_core_access: got en=%b addr=%h expected en=1 addr=10",
                   bus.mem_en, bus.mem_addr);
        end
      end
      if (bus.core_ack || bus.dbg_ack) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_errors++;
          $display("FAIL abort_sb: unexpected ack at c=%0d, expected none", c);
        end else begin
          e = sb.pop_front();
          if ({bus.dbg_ack, bus.dbg_ack ? bus.dbg_rdata : bus.core_rdata} !== e) begin
            n_errors++;
            $display("FAIL abort_data: got port=%b data=%0d expected port=%b data=%0d",
                     bus.dbg_ack, bus.dbg_ack ? bus.dbg_rdata : bus.core_rdata, e.dbg, e.data);
          end
        end
      end
      step();
      if (c == 1) reset = 1'b1;
      if (c == 2) begin
        reset       = 1'b0;
        bus.dbg_req = 1'b0;
      end
      if (c == 4) begin
        bus.core_req  = 1'b1;
        bus.core_we   = 1'b0;
        bus.core_addr = 32'h10;
        sb.push_back('{1'b0, 32'd30});
      end
      if (c == 9) bus.core_req = 1'b0;
    end
  endtask

  task automatic test_lat1();
    exp_t e;
    mem1[8'h08] = 32'd7;
    bus1.core_req  = 1'b1;
    bus1.core_we   = 1'b0;
    bus1.core_addr = 32'h8;
    sb.push_back('{1'b0, 32'd7});
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      n_checks++;
      if ({bus1.mem_en, bus1.core_ack} !== {1'(c == 1), 1'(c == 3)}) begin
        n_errors++;
        $display("FAIL lat1_timing c=%0d: got en=%b ack=%b expected en=%b ack=%b",
                 c, bus1.mem_en, bus1.core_ack, (c == 1), (c == 3));
      end
      if (bus1.core_ack) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_errors++;
          $display("FAIL lat1_sb: unexpected ack at c=%0d, expected none", c);
        end else begin
          e = sb.pop_front();
          if ({1'b0, bus1.core_rdata} !== e) begin
            n_errors++;
            $display("FAIL lat1_data: got %0d expected %0d", bus1.core_rdata, e.data);
          end
        end
      end
      step();
      if (c == 3) bus1.core_req = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 32'(i) ^ 32'h5A5A_0000;
      mem1[i] = 32'(i) ^ 32'hA5A5_0000;
    end
    bus.core_req   = 1'b0;
    bus.core_we    = 1'b0;
    bus.core_addr  = '0;
    bus.core_wdata = '0;
    bus.dbg_req    = 1'b0;
    bus.dbg_we     = 1'b0;
    bus.dbg_addr   = '0;
    bus.dbg_wdata  = '0;
    bus1.core_req   = 1'b0;
    bus1.core_we    = 1'b0;
    bus1.core_addr  = '0;
    bus1.core_wdata = '0;
    bus1.dbg_req    = 1'b0;
    bus1.dbg_we     = 1'b0;
    bus1.dbg_addr   = '0;
    bus1.dbg_wdata  = '0;

    test_reset();
    test_core_load();
    test_dbg_write_core_read();
    test_back_to_back();
    test_addr_change();
    test_reset_abort();
    test_lat1();

    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL sb_drained: %0d responses outstanding, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
